// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed 7-segment bus reader, decodes scanned digits back to hex nibbles
// Optional decimal-point monitoring is enabled with `define SEG7_DP_EN.
module seg7_scan_decoder #(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_n_i,
    input  logic [N_DIG-1:0]     dig_sel_n_i,
`ifdef SEG7_DP_EN
    input  logic                 dp_n_i,
    output logic [N_DIG-1:0]     dp_o,
`endif
    output logic [4*N_DIG-1:0]   value_o,
    output logic [N_DIG-1:0]     err_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ovf_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [8:0] STABLE_LIM = 9'(STABLE_CYC);

    state_t               state, state_d;
    logic [7:0]           cnt, cnt_d;
    logic [8:0]           cnt_inc;

    logic [6:0]           seg_m, seg_s, seg_p;
    logic [N_DIG-1:0]     dig_m, dig_s, dig_p;
    logic                 dp_same;
    logic                 dp_lit;

    logic [N_DIG-1:0]     sel_s, sel_p;
    logic                 legal, same, cap;

    logic [4*N_DIG-1:0]   sh_val, sh_val_nxt;
    logic [N_DIG-1:0]     sh_err, sh_err_nxt;
    logic [N_DIG-1:0]     sh_dp, sh_dp_nxt;
    logic [N_DIG-1:0]     bitmap, bitmap_nxt;
    logic                 frame_done, out_free;
    logic [4:0]           dec;

    // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
    function automatic logic [4:0] decode7(input logic [6:0] p);
        case (p)
            7'h40:   decode7 = 5'h00;
            7'h79:   decode7 = 5'h01;
            7'h24:   decode7 = 5'h02;
            7'h30:   decode7 = 5'h03;
            7'h19:   decode7 = 5'h04;
            7'h12:   decode7 = 5'h05;
            7'h02:   decode7 = 5'h06;
            7'h78:   decode7 = 5'h07;
            7'h00:   decode7 = 5'h08;
            7'h18:   decode7 = 5'h09;
            7'h08:   decode7 = 5'h0A;
            7'h03:   decode7 = 5'h0B;
            7'h46:   decode7 = 5'h0C;
            7'h21:   decode7 = 5'h0D;
            7'h06:   decode7 = 5'h0E;
            7'h0E:   decode7 = 5'h0F;
            default: decode7 = 5'h10;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '0;
            seg_s <= '0;
            seg_p <= '0;
            dig_m <= '0;
            dig_s <= '0;
            dig_p <= '0;
        end else begin
            seg_m <= seg_n_i;
            seg_s <= seg_m;
            seg_p <= seg_s;
            dig_m <= dig_sel_n_i;
            dig_s <= dig_m;
            dig_p <= dig_s;
        end
    end

`ifdef SEG7_DP_EN
    logic dp_m, dp_s, dp_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_m <= 1'b0;
            dp_s <= 1'b0;
            dp_p <= 1'b0;
        end else begin
            dp_m <= dp_n_i;
            dp_s <= dp_m;
            dp_p <= dp_s;
        end
    end

    assign dp_same = (dp_s == dp_p);
    assign dp_lit  = ~dp_p;
`else
    assign dp_same = 1'b1;
    assign dp_lit  = 1'b0;
`endif

    assign sel_s   = ~dig_s;
    assign sel_p   = ~dig_p;
    assign legal   = (sel_s != '0) && ((sel_s & (sel_s - 1'b1)) == '0);
    assign same    = (seg_s == seg_p) && (dig_s == dig_p) && dp_same;
    assign cnt_inc = {1'b0, cnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // A change seen during CAPTURE must restart settling, otherwise HOLD would
    // compare against the already-updated previous sample and miss it.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (legal) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            SETTLE: begin
                if (!legal) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d   = cnt_inc[7:0];
                    if (cnt_inc == STABLE_LIM)
                        state_d = CAPTURE;
                end
            end
            CAPTURE, HOLD: begin
                if (!legal) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!same) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else if (state == CAPTURE) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // In CAPTURE the previous-sample registers hold the value that was counted stable.
    assign cap = (state == CAPTURE);
    assign dec = decode7(seg_p);

    always_comb begin
        sh_val_nxt = sh_val;
        sh_err_nxt = sh_err;
        sh_dp_nxt  = sh_dp;
        bitmap_nxt = bitmap;
        for (int k = 0; k < N_DIG; k++) begin
            if (cap && sel_p[k]) begin
                sh_val_nxt[4*k +: 4] = dec[3:0];
                sh_err_nxt[k]        = dec[4];
                sh_dp_nxt[k]         = dp_lit;
                bitmap_nxt[k]        = 1'b1;
            end
        end
    end

    assign frame_done = cap && (&bitmap_nxt);
    assign out_free   = !valid_o || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val  <= '0;
            sh_err  <= '0;
            sh_dp   <= '0;
            bitmap  <= '0;
            value_o <= '0;
            err_o   <= '0;
            valid_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            sh_val <= sh_val_nxt;
            sh_dp  <= sh_dp_nxt;
            ovf_o  <= frame_done && !out_free;
            if (frame_done) begin
                bitmap <= '0;
                sh_err <= '0;
            end else begin
                bitmap <= bitmap_nxt;
                sh_err <= sh_err_nxt;
            end
            if (frame_done && out_free) begin
                value_o <= sh_val_nxt;
                err_o   <= sh_err_nxt;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef SEG7_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dp_o <= '0;
        else if (frame_done && out_free)
            dp_o <= sh_dp_nxt;
    end
`else
    logic unused_dp;
    assign unused_dp = &{1'b0, sh_dp, dp_lit};
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - table-driven bench for seg7_scan_decoder (N_DIG=4, STABLE_CYC=4)
module tb_seg7_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   seg_n = 7'h7F;
    logic [3:0]   dig_n = 4'hF;
    logic         ready = 1'b1;
    logic [15:0]  value_o;
    logic [3:0]   err_o;
    logic         valid_o;
    logic         ovf_o;
`ifdef SEG7_DP_EN
    logic         dp_n = 1'b1;
    logic [3:0]   dp_o;
    logic [3:0]   last_dp;
`endif

    seg7_scan_decoder #(.N_DIG(N), .STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n_i     (seg_n),
        .dig_sel_n_i (dig_n),
`ifdef SEG7_DP_EN
        .dp_n_i      (dp_n),
        .dp_o        (dp_o),
`endif
        .value_o     (value_o),
        .err_o       (err_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          frames = 0;
    int          ovfs = 0;
    logic [15:0] last_val = '0;
    logic [3:0]  last_err = '0;

    always @(negedge clk) begin
        if (rst_n && valid_o && ready) begin
            frames++;
            last_val = value_o;
            last_err = err_o;
`ifdef SEG7_DP_EN
            last_dp = dp_o;
`endif
        end
        if (rst_n && ovf_o)
            ovfs++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int k, input logic [6:0] p, input int hold, input logic dp_on);
        dig_n = ~(4'(1) << k);
        seg_n = p;
`ifdef SEG7_DP_EN
        dp_n = ~dp_on;
`endif
        tick(hold);
    endtask

    task automatic go_idle();
        dig_n = 4'hF;
        seg_n = 7'h7F;
`ifdef SEG7_DP_EN
        dp_n = 1'b1;
`endif
        tick(8);
    endtask

    task automatic scan(input logic [3:0][6:0] p, input int hold, input logic [3:0] dpm);
        for (int k = 0; k < N; k++)
            drive_digit(k, p[k], hold, dpm[k]);
        go_idle();
    endtask

    typedef struct {
        logic [3:0][6:0] segs;
        int              hold;
        int              nfr;
        logic [15:0]     val;
        logic [3:0]      err;
    } vec_t;

    vec_t v[5];
    int   f0;
    int   o0;

    initial begin
        v[0] = '{segs: {7'h79, 7'h46, 7'h08, 7'h30}, hold: 10, nfr: 1, val: 16'h1CA3, err: 4'b0000};
        v[1] = '{segs: {7'h30, 7'h7F, 7'h79, 7'h40}, hold: 10, nfr: 1, val: 16'h3010, err: 4'b0100};
        v[2] = '{segs: {7'h78, 7'h02, 7'h12, 7'h24}, hold: 3,  nfr: 0, val: 16'h0000, err: 4'b0000};
        v[3] = '{segs: {7'h21, 7'h03, 7'h18, 7'h00}, hold: 10, nfr: 1, val: 16'hDB98, err: 4'b0000};
        v[4] = '{segs: {7'h7F, 7'h19, 7'h0E, 7'h06}, hold: 10, nfr: 1, val: 16'h04FE, err: 4'b1000};

        rst_n = 1'b0;
        tick(3);
        check("reset_value", 32'(value_o), 32'h0);
        check("reset_err",   32'(err_o),   32'h0);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_ovf",   32'(ovf_o),   32'h0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            f0 = frames;
            scan(v[i].segs, v[i].hold, 4'b0000);
            check($sformatf("vec%0d_frames", i), 32'(frames - f0), 32'(v[i].nfr));
            if (v[i].nfr > 0) begin
                check($sformatf("vec%0d_value", i), 32'(last_val), 32'(v[i].val));
                check($sformatf("vec%0d_err", i),   32'(last_err), 32'(v[i].err));
            end
            check($sformatf("vec%0d_valid_idle", i), 32'(valid_o), 32'h0);
        end

        // Backpressure: first frame held, second dropped with one ovf pulse.
        ready = 1'b0;
        f0 = frames;
        o0 = ovfs;
        scan({7'h79, 7'h46, 7'h08, 7'h30}, 10, 4'b0000);
        check("bp_valid_held", 32'(valid_o), 32'h1);
        check("bp_value_held", 32'(value_o), 32'h1CA3);
        scan({7'h30, 7'h24, 7'h79, 7'h40}, 10, 4'b0000);
        check("bp_ovf_pulses", 32'(ovfs - o0), 32'h1);
        check("bp_value_kept", 32'(value_o), 32'h1CA3);
        ready = 1'b1;
        tick(2);
        check("bp_valid_drop", 32'(valid_o), 32'h0);
        check("bp_frames", 32'(frames - f0), 32'h1);
        check("bp_last_val", 32'(last_val), 32'h1CA3);

        // Two strobes active: nothing captured; digits 2,3 then 0,1 form exactly one frame.
        f0 = frames;
        dig_n = 4'b1100;
        seg_n = 7'h30;
        tick(20);
        go_idle();
        check("multi_strobe_frames", 32'(frames - f0), 32'h0);
        drive_digit(2, 7'h46, 10, 1'b0);
        drive_digit(3, 7'h79, 10, 1'b0);
        go_idle();
        check("half_frame_none", 32'(frames - f0), 32'h0);
        drive_digit(0, 7'h30, 10, 1'b0);
        drive_digit(1, 7'h08, 10, 1'b0);
        go_idle();
        check("split_frame_count", 32'(frames - f0), 32'h1);
        check("split_frame_value", 32'(last_val), 32'h1CA3);

        // Reset mid-frame with a pending output, then verify partial captures are gone.
        ready = 1'b0;
        scan({7'h21, 7'h03, 7'h18, 7'h00}, 10, 4'b0000);
        check("pre_reset_valid", 32'(valid_o), 32'h1);
        drive_digit(0, 7'h40, 10, 1'b0);
        drive_digit(1, 7'h79, 10, 1'b0);
        rst_n = 1'b0;
        dig_n = 4'hF;
        seg_n = 7'h7F;
        tick(2);
        check("midrst_value", 32'(value_o), 32'h0);
        check("midrst_err",   32'(err_o),   32'h0);
        check("midrst_valid", 32'(valid_o), 32'h0);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(2);
        f0 = frames;
        drive_digit(2, 7'h24, 10, 1'b0);
        drive_digit(3, 7'h30, 10, 1'b0);
        go_idle();
        check("post_rst_partial", 32'(frames - f0), 32'h0);
        scan({7'h30, 7'h24, 7'h79, 7'h40}, 10, 4'b0000);
        check("post_rst_frames", 32'(frames - f0), 32'h1);
        check("post_rst_value", 32'(last_val), 32'h3210);

`ifdef SEG7_DP_EN
        f0 = frames;
        scan({7'h79, 7'h46, 7'h08, 7'h30}, 10, 4'b0010);
        check("dp_frames", 32'(frames - f0), 32'h1);
        check("dp_mask", 32'(last_dp), 32'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
